// File: rtl/sr_pkg.sv
// sr_pkg: types and constants shared by the SR flip-flop stimulus checker.
//   state_e          - checker FSM states
//   PAT_*            - the four {s,r} drive patterns, in application order
//   pattern_for_step - maps a 2-bit step index onto its {s,r} pattern
package sr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] PAT_HOLD  = 2'b00;
  localparam logic [1:0] PAT_RESET = 2'b01;
  localparam logic [1:0] PAT_SET   = 2'b10;
  localparam logic [1:0] PAT_BOTH  = 2'b11;

  function automatic logic [1:0] pattern_for_step(input logic [1:0] step);
    logic [1:0] pat;
    case (step)
      2'd0:    pat = PAT_HOLD;
      2'd1:    pat = PAT_RESET;
      2'd2:    pat = PAT_SET;
      default: pat = PAT_BOTH;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/sr_ref_model.sv
// sr_ref_model: behavioural reference of an SR flip-flop used to predict q.
// Ports:
//   clk, rst    - clock, asynchronous active-low reset
//   s, r        - drive values being applied this step
//   step        - strobe: absorb {s,r} into the model on this edge
//   init        - strobe: force model to known, q=0 (run start)
//   exp_q       - predicted q after the last absorbed step
//   exp_known   - prediction is valid (cleared by {s,r}=11)
module sr_ref_model
  import sr_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic r,
  input  logic step,
  input  logic init,
  output logic exp_q,
  output logic exp_known
);

  logic exp_q_q, exp_q_d;
  logic known_q, known_d;

  always_comb begin
    exp_q_d = exp_q_q;
    known_d = known_q;
    if (init) begin
      exp_q_d = 1'b0;
      known_d = 1'b1;
    end else if (step) begin
      case ({s, r})
        PAT_RESET: begin exp_q_d = 1'b0; known_d = 1'b1; end
        PAT_SET:   begin exp_q_d = 1'b1; known_d = 1'b1; end
        // Both inputs active leaves the real flop's state undefined; a
        // following hold keeps it undefined until a set or reset.
        PAT_BOTH:  known_d = 1'b0;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q_q <= 1'b0;
      known_q <= 1'b1;
    end else begin
      exp_q_q <= exp_q_d;
      known_q <= known_d;
    end
  end

  assign exp_q     = exp_q_q;
  assign exp_known = known_q;

endmodule

// File: rtl/sr_stim_checker.sv
// sr_stim_checker: drives an external SR flip-flop through the pattern
// sequence 00,01,10,11 (LOOPS times) and counts steps whose q/qbar disagree
// with a reference model.
// Ports:
//   clk, rst   - clock, asynchronous active-low reset
//   start      - one-cycle run request (honoured in IDLE or DONE only)
//   s, r       - registered drives to the flop under test
//   q, qbar    - flop under test outputs
//   busy       - run in progress (APPLY/CHECK)
//   done       - run finished (level, DONE state)
//   pass       - done with zero errors
//   err_count  - failing checked steps, saturating
// Each step is two cycles: APPLY (flop captures {s,r} at its end) then CHECK
// (q/qbar compared at its end), so a run takes 8*LOOPS cycles.
module sr_stim_checker
  import sr_pkg::*;
#(
  parameter int LOOPS = 1,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             s,
  output logic             r,
  input  logic             q,
  input  logic             qbar,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [7:0]       LAST_LOOP = 8'(LOOPS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

  state_e           state_q, state_d;
  logic [1:0]       step_q, step_d;
  logic [7:0]       loop_q, loop_d;
  logic             s_q, s_d;
  logic             r_q, r_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic model_step;
  logic model_init;
  logic exp_q;
  logic exp_known;
  logic final_step;
  logic step_fail;

  sr_ref_model u_ref (
    .clk       (clk),
    .rst       (rst),
    .s         (s_q),
    .r         (r_q),
    .step      (model_step),
    .init      (model_init),
    .exp_q     (exp_q),
    .exp_known (exp_known)
  );

  assign final_step = (step_q == 2'd3) && (loop_q == LAST_LOOP);
  // A healthy flop must match the prediction and have complementary outputs.
  assign step_fail  = exp_known && ((q != exp_q) || (qbar == q));

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    loop_d     = loop_q;
    s_d        = s_q;
    r_d        = r_q;
    err_d      = err_q;
    model_step = 1'b0;
    model_init = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_APPLY;
          step_d     = 2'd0;
          loop_d     = 8'd0;
          {s_d, r_d} = pattern_for_step(2'd0);
          err_d      = '0;
          model_init = 1'b1;
        end
      end
      ST_APPLY: begin
        // The flop under test captures {s,r} on this edge; so does the model.
        model_step = 1'b1;
        state_d    = ST_CHECK;
      end
      ST_CHECK: begin
        if (step_fail && (err_q != ERR_MAX)) begin
          err_d = err_q + ERR_W'(1);
        end
        if (final_step) begin
          state_d    = ST_DONE;
          step_d     = 2'd0;
          loop_d     = 8'd0;
          {s_d, r_d} = PAT_HOLD;
        end else begin
          state_d    = ST_APPLY;
          step_d     = step_q + 2'd1;
          if (step_q == 2'd3) begin
            loop_d = loop_q + 8'd1;
          end
          {s_d, r_d} = pattern_for_step(step_q + 2'd1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      step_q  <= 2'd0;
      loop_q  <= 8'd0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      loop_q  <= loop_d;
      s_q     <= s_d;
      r_q     <= r_d;
      err_q   <= err_d;
    end
  end

  assign s         = s_q;
  assign r         = r_q;
  assign busy      = (state_q == ST_APPLY) || (state_q == ST_CHECK);
  assign done      = (state_q == ST_DONE);
  assign pass      = done && (err_q == '0);
  assign err_count = err_q;

endmodule

// File: doc/sr_stim_checker.md
SR_STIM_CHECKER -- requirements
Module: sr_stim_checker

Interface
REQ-001 Parameter LOOPS, default 1: number of passes through the 4-step pattern sequence per run; legal range 1..255.
REQ-002 Parameter ERR_W, default 8: width of the error counter.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  single-cycle run request; sampled only in IDLE or DONE.
REQ-006 s  output  1  registered set drive to the SR flip-flop under test.
REQ-007 r  output  1  registered reset drive to the SR flip-flop under test.
REQ-008 q  input  1  flip-flop true output.
REQ-009 qbar  input  1  flip-flop complement output.
REQ-010 busy  output  1  high in APPLY and CHECK states.
REQ-011 done  output  1  level, high in DONE state.
REQ-012 pass  output  1  done AND err_count == 0.
REQ-013 err_count  output  ERR_W  number of failing checked steps in the current or last run.

Function
REQ-014 FSM states: IDLE, APPLY, CHECK, DONE.
REQ-015 Transitions: IDLE --start--> APPLY; APPLY --> CHECK (always); CHECK --> APPLY if steps remain, else DONE; DONE --start--> APPLY.
REQ-016 Pattern order for {s,r}: 00, 01, 10, 11; repeated LOOPS times; 4*LOOPS steps per run.
REQ-017 {s,r} loaded on the edge entering APPLY and held through the following CHECK cycle; {s,r} = 00 in IDLE and DONE.
REQ-018 The DUT captures {s,r} on the edge ending APPLY; q/qbar are compared on the edge ending CHECK.
REQ-019 Expected-state model: 00 holds; 01 sets expected q=0, known; 10 sets expected q=1, known; 11 marks expected state unknown.
REQ-020 A step is checked only when the expected state is known after the step; steps with expected state unknown (11, and 00 following 11) are not checked.
REQ-021 A checked step fails if q != expected q OR qbar != ~q; each failing step increments err_count by exactly 1.
REQ-022 err_count saturates at 2^ERR_W-1 and never wraps.
REQ-023 Expected model is initialised to known, q=0 at reset and at each run start.
REQ-024 start in DONE clears err_count and done on the same edge that enters APPLY.
REQ-025 start while busy is ignored; a run is neither restarted nor extended.
REQ-026 Latency: with start sampled at edge T0, done rises at edge T0 + 8*LOOPS.

Reset
REQ-027 On rst low, immediately: state=IDLE, s=0, r=0, busy=0, done=0, pass=0, err_count=0, step and loop counters 0, expected model known q=0.
REQ-028 Reset asserted mid-run aborts the run without a done indication; after release the block waits in IDLE for start.

Structure
REQ-029 Shared package sr_pkg holds the FSM state enum and the four {s,r} pattern constants.
REQ-030 The expected-state model is the sub-module sr_ref_model (inputs: s, r, step-strobe, init; outputs: exp_q, exp_known).
REQ-031 Step index (2 bits) and loop counter (8 bits) are separate registers; the final step is step==3 AND loop==LOOPS-1.

Verification
REQ-032 Correct SR flip-flop, LOOPS=1, start at T0 -> s,r sequence 00,01,10,11 at 2-cycle spacing; done at T0+8; err_count=0; pass=1.
REQ-033 Faulty DUT with q stuck at 0 and qbar = ~q, LOOPS=2 -> err_count=2 (one per 10 step); pass=0.
REQ-034 Stuck DUT, LOOPS=5, ERR_W=2 -> err_count saturates at 3; no wrap.
REQ-035 Pulse start again during CHECK of step 1 -> ignored; done still at T0+8*LOOPS.
REQ-036 Assert rst low during the third APPLY -> s=r=0, busy=0, err_count=0 immediately; no done; a later start runs a full clean sequence.
REQ-037 From DONE with err_count=1, pulse start -> done=0 and err_count=0 on the next edge; the new run completes normally.
